// File: rtl/regfile_mp.sv
// Parametrised register file with NUM_RD independent read ports, per-bit write
// mask, optional registered reads with write bypass and a sequential clear engine.
module regfile_mp #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = 2,
   parameter int REG_RD = 0,
   parameter int BYPASS = 1
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     cs_n,
   input  logic                     w_en_n,
   input  logic [ADDR_W-1:0]        w_addr,
   input  logic [DATA_W-1:0]        w_data,
   input  logic [DATA_W-1:0]        w_mask,
   input  logic [NUM_RD*ADDR_W-1:0] r_addr,
   output logic [NUM_RD*DATA_W-1:0] r_data,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     clr_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   // Address decode over the real entries only, so out-of-range reads give 0.
   function automatic logic [DATA_W-1:0] read_word(
      input logic [DEPTH-1:0][DATA_W-1:0] arr,
      input logic [ADDR_W-1:0]            addr
   );
      logic [DATA_W-1:0] word;
      word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == ADDR_W'(i)) word = arr[i];
      end
      return word;
   endfunction

   state_t                       state_q, state_d;
   logic [ADDR_W-1:0]            cnt_q, cnt_d;
   logic                         busy_q, busy_d;
   logic                         clr_done_q, clr_done_d;
   logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_c, mem_d;
   logic                         wr_en;
   logic                         clr_en;
   logic [DATA_W-1:0]            wr_old;
   logic [DATA_W-1:0]            wr_word;

   assign wr_en   = ~cs_n & ~w_en_n & ~busy_q & ({1'b0, w_addr} < DEPTH_X);
   assign clr_en  = (state_q == ST_CLEAR);
   assign wr_old  = read_word(mem_q, w_addr);
   assign wr_word = (wr_old & ~w_mask) | (w_data & w_mask);

   // mem_c: array after this edge's clear step only; mem_d adds the user write.
   always_comb begin
      mem_c = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (clr_en && (cnt_q == ADDR_W'(i))) mem_c[i] = '0;
      end
   end

   always_comb begin
      mem_d = mem_c;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en && (w_addr == ADDR_W'(i))) mem_d[i] = wr_word;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         clr_done_q <= clr_done_d;
      end
   end

   // clr_req outside IDLE is ignored rather than queued.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Status flags are registered from the next state so they align with it.
   always_comb begin
      busy_d     = (state_d == ST_CLEAR);
      clr_done_d = (state_d == ST_DONE);
   end

   assign busy     = busy_q;
   assign clr_done = clr_done_q;

   generate
      if (REG_RD != 0) begin : g_reg_rd
         logic [DEPTH-1:0][DATA_W-1:0] rd_src;
         logic [NUM_RD*DATA_W-1:0]     rd_d;
         logic [NUM_RD*DATA_W-1:0]     rd_q;

         // Clear steps always land in the read register; user writes only with BYPASS.
         assign rd_src = (BYPASS != 0) ? mem_d : mem_c;

         always_comb begin
            rd_d = '0;
            for (int p = 0; p < NUM_RD; p++) begin
               rd_d[p*DATA_W +: DATA_W] = read_word(rd_src, r_addr[p*ADDR_W +: ADDR_W]);
            end
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               rd_q <= '0;
            end else begin
               rd_q <= rd_d;
            end
         end

         assign r_data = rd_q;
      end else begin : g_comb_rd
         always_comb begin
            r_data = '0;
            for (int p = 0; p < NUM_RD; p++) begin
               r_data[p*DATA_W +: DATA_W] = read_word(mem_q, r_addr[p*ADDR_W +: ADDR_W]);
            end
         end
      end
   endgenerate

endmodule
